// File: rtl/native_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package : native_mem_pkg
// Desc    : Shared types for the picorv32 native memory responder.
// Rev     : 1.0  initial release
// ============================================================================
package native_mem_pkg;

    localparam int NM_WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } nm_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } nm_req_t;

endpackage
`default_nettype wire

// File: rtl/native_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Interface : native_mem_slave_if
// Desc      : picorv32 native memory bus (mem_* signals) with modports.
// Rev       : 1.0  initial release
// ============================================================================
interface native_mem_slave_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/native_mem_slave_ram.sv
`default_nettype none
// ============================================================================
// Module : native_mem_ram
// Desc   : Word RAM with byte-strobed CPU write merged with a preload write,
//          asynchronous read. Contents are never reset.
// Rev    : 1.0  initial release
// ============================================================================
module native_mem_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [31:0]       wr_data,
    input  wire logic [3:0]        wr_strb,
    input  wire logic              ld_we,
    input  wire logic [ADDR_W-1:0] ld_addr,
    input  wire logic [31:0]       ld_data,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic      [31:0]       rd_data
);

    logic [31:0] r_mem [MEM_WORDS];

    // Preload goes first so that CPU-strobed bytes override it on a collision.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/native_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : native_mem_slave
// Desc   : Wait-stated RAM responder for the picorv32 native memory port.
//          Optional alignment checking via NATIVE_MEM_MISALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module native_mem_slave
    import native_mem_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    native_mem_slave_if.slave bus,
    input  wire logic         ld_we,
    input  wire logic [31:0]  ld_addr,
    input  wire logic [31:0]  ld_data,
    output logic              err,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       xfer_cnt
);

    localparam int                   ADDR_W      = $clog2(MEM_WORDS);
    localparam logic [31:0]          C_MEM_WORDS = 32'(MEM_WORDS);
    localparam logic [NM_WAIT_W-1:0] C_WAIT      = NM_WAIT_W'(WAIT_CYCLES);

    nm_state_t            r_state, w_next_state;
    logic [NM_WAIT_W-1:0] r_wait_cnt, w_wait_next;
    nm_req_t              r_req, w_req_in, w_req;
    logic                 w_accept, w_enter_resp;
    logic [31:0]          w_word, w_ram_rdata, r_rdata;
    logic                 w_oob, w_misalign, w_bad;
    logic                 w_unused_ld;

    assign w_req_in = '{addr:  bus.mem_addr,  wdata: bus.mem_wdata,
                        wstrb: bus.mem_wstrb, instr: bus.mem_instr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    w_accept    = 1'b1;
                    w_wait_next = C_WAIT;
                    if (C_WAIT == '0) begin
                        w_next_state = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt <= NM_WAIT_W'(1)) begin
                    w_next_state = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_wait_next = r_wait_cnt - NM_WAIT_W'(1);
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the live bus request is used instead of the latched copy.
    assign w_req  = w_accept ? w_req_in : r_req;
    assign w_word = w_req.addr >> 2;
    assign w_oob  = (w_word >= C_MEM_WORDS);

`ifdef NATIVE_MEM_MISALIGN_CHECK_EN
    assign w_misalign = (w_req.addr[1:0] != 2'b00) &&
                        ((w_req.wstrb != 4'b0000) || w_req.instr);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_bad       = w_oob | w_misalign;
    assign w_unused_ld = ^ld_addr[31:ADDR_W];

    native_mem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_enter_resp && !w_bad && (w_req.wstrb != 4'b0000)),
        .wr_addr (w_word[ADDR_W-1:0]),
        .wr_data (w_req.wdata),
        .wr_strb (w_req.wstrb),
        .ld_we   (ld_we),
        .ld_addr (ld_addr[ADDR_W-1:0]),
        .ld_data (ld_data),
        .rd_addr (w_word[ADDR_W-1:0]),
        .rd_data (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req     <= '0;
            r_rdata   <= '0;
            err       <= 1'b0;
            fetch_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_enter_resp) begin
                xfer_cnt <= xfer_cnt + 32'd1;
                if (w_req.instr) begin
                    fetch_cnt <= fetch_cnt + 32'd1;
                end
                if (w_bad) begin
                    err <= 1'b1;
                end
                if (w_req.wstrb == 4'b0000) begin
                    r_rdata <= w_bad ? 32'd0 : w_ram_rdata;
                end
            end
        end
    end

    assign bus.mem_ready = (r_state == ST_RESP);
    assign bus.mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_native_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_native_mem_slave
// Desc   : Directed self-checking bench; three instances with WAIT_CYCLES 2/0/3.
// Rev    : 1.0  initial release
// ============================================================================
module tb_native_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [3];
    logic        valid   [3];
    logic        instr   [3];
    logic [31:0] addr    [3];
    logic [31:0] wdata   [3];
    logic [3:0]  wstrb   [3];
    logic        ld_we   [3];
    logic [31:0] ld_addr [3];
    logic [31:0] ld_data [3];
    logic        rdy     [3];
    logic [31:0] rdata   [3];
    logic        err     [3];
    logic [31:0] fcnt    [3];
    logic [31:0] xcnt    [3];

    int n_vec = 0;
    int n_err = 0;

    native_mem_slave_if bus0 ();
    native_mem_slave_if bus1 ();
    native_mem_slave_if bus2 ();

    assign bus0.mem_valid = valid[0]; assign bus0.mem_instr = instr[0];
    assign bus0.mem_addr  = addr[0];  assign bus0.mem_wdata = wdata[0];
    assign bus0.mem_wstrb = wstrb[0];
    assign rdy[0] = bus0.mem_ready;   assign rdata[0] = bus0.mem_rdata;
    assign bus1.mem_valid = valid[1]; assign bus1.mem_instr = instr[1];
    assign bus1.mem_addr  = addr[1];  assign bus1.mem_wdata = wdata[1];
    assign bus1.mem_wstrb = wstrb[1];
    assign rdy[1] = bus1.mem_ready;   assign rdata[1] = bus1.mem_rdata;
    assign bus2.mem_valid = valid[2]; assign bus2.mem_instr = instr[2];
    assign bus2.mem_addr  = addr[2];  assign bus2.mem_wdata = wdata[2];
    assign bus2.mem_wstrb = wstrb[2];
    assign rdy[2] = bus2.mem_ready;   assign rdata[2] = bus2.mem_rdata;

    native_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .bus(bus0.slave), .ld_we(ld_we[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .err(err[0]),
        .fetch_cnt(fcnt[0]), .xfer_cnt(xcnt[0]));
    native_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst[1]), .bus(bus1.slave), .ld_we(ld_we[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .err(err[1]),
        .fetch_cnt(fcnt[1]), .xfer_cnt(xcnt[1]));
    native_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(rst[2]), .bus(bus2.slave), .ld_we(ld_we[2]),
        .ld_addr(ld_addr[2]), .ld_data(ld_data[2]), .err(err[2]),
        .fetch_cnt(fcnt[2]), .xfer_cnt(xcnt[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int k, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
        @(negedge clk);
        ld_we[k] = 1'b0;
    endtask

    // Returns in the IDLE cycle after RESP. The bus is scrambled after accept;
    // an optional preload is driven so that it lands on the edge closing cycle ld_cyc.
    task automatic access(input int k, input logic ins, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input int ld_cyc, input logic [31:0] la, input logic [31:0] ldd,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        valid[k] = 1'b1; instr[k] = ins; addr[k] = a; wdata[k] = wd; wstrb[k] = ws;
        @(posedge clk); #1;
        addr[k] = 32'hFFFF_FFF0; wdata[k] = 32'hFFFF_FFFF; wstrb[k] = 4'hF; instr[k] = ~ins;
        lat = 0; rd = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            if (c == ld_cyc) begin
                ld_we[k] = 1'b1; ld_addr[k] = la; ld_data[k] = ldd;
            end
            @(negedge clk);
            if (rdy[k]) begin
                lat = c; rd = rdata[k];
                break;
            end
            @(posedge clk); #1;
            ld_we[k] = 1'b0;
        end
        valid[k] = 1'b0; wstrb[k] = 4'h0; instr[k] = 1'b0;
        @(posedge clk); #1;
        ld_we[k] = 1'b0;
        if (lat == 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    int          lat;
    int          cyc [3];
    int          n;
    logic        seen;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; valid[k] = 1'b0; instr[k] = 1'b0; addr[k] = '0;
            wdata[k] = '0; wstrb[k] = '0; ld_we[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);

        check("rst_ready",  {31'd0, rdy[0]}, 32'd0);
        check("rst_rdata",  rdata[0],        32'd0);
        check("rst_err",    {31'd0, err[0]}, 32'd0);
        check("rst_fetch",  fcnt[0],         32'd0);
        check("rst_xfer",   xcnt[0],         32'd0);

        // Fetch with WAIT_CYCLES=2
        preload(0, 32'd0, 32'h0050_0093);
        access(0, 1'b1, 32'h0, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("fetch_lat",   32'(lat), 32'd3);
        check("fetch_rdata", rd,       32'h0050_0093);
        check("fetch_fcnt",  fcnt[0],  32'd1);
        check("fetch_xcnt",  xcnt[0],  32'd1);

        // Byte-strobed write, rdata must not change on a write
        preload(0, 32'd4, 32'h1122_3344);
        access(0, 1'b0, 32'h10, 32'hAABB_CCDD, 4'b0010, -1, 32'h0, 32'h0, rd, lat);
        check("wr_lat",      32'(lat), 32'd3);
        check("wr_rdata",    rd,       32'h0050_0093);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("strb_merge",  rd,       32'h1122_CC44);
        check("cnt_fcnt",    fcnt[0],  32'd1);
        check("cnt_xcnt",    xcnt[0],  32'd3);

        // Preload and CPU commit on the same word and edge
        access(0, 1'b0, 32'h14, 32'h0000_00AA, 4'b0001, 2, 32'd5, 32'h5566_7788, rd, lat);
        access(0, 1'b0, 32'h14, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("collide",     rd,       32'h5566_77AA);

        // Preload index wraps modulo MEM_WORDS
        preload(0, 32'd1031, 32'h0BAD_F00D);
        access(0, 1'b0, 32'h1C, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("ld_wrap",     rd,       32'h0BAD_F00D);
        check("pre_oob_err", {31'd0, err[0]}, 32'd0);

        // Out of range
        access(0, 1'b0, 32'h1000, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("oob_lat",     32'(lat), 32'd3);
        check("oob_rdata",   rd,       32'd0);
        check("oob_err",     {31'd0, err[0]}, 32'd1);
        access(0, 1'b0, 32'h1000, 32'hFFFF_FFFF, 4'hF, -1, 32'h0, 32'h0, rd, lat);
        access(0, 1'b0, 32'h0, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("oob_no_alias", rd,      32'h0050_0093);
        check("err_sticky",  {31'd0, err[0]}, 32'd1);

        // Back-to-back with WAIT_CYCLES=0
        check("b2b_xcnt0",   xcnt[1],  32'd0);
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = 32'h0; wstrb[1] = 4'h0; instr[1] = 1'b0;
        n = 0;
        for (int c = 1; c <= 30 && n < 3; c++) begin
            @(negedge clk);
            if (rdy[1]) begin
                cyc[n] = c; n++;
                if (n == 3) valid[1] = 1'b0;
            end
        end
        valid[1] = 1'b0;
        check("b2b_count",   32'(n), 32'd3);
        check("b2b_first",   32'(cyc[0]), 32'd1);
        check("b2b_gap1",    32'(cyc[1] - cyc[0]), 32'd2);
        check("b2b_gap2",    32'(cyc[2] - cyc[1]), 32'd2);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= rdy[1]; end
        check("b2b_no_extra", {31'd0, seen}, 32'd0);
        check("b2b_xcnt",    xcnt[1],  32'd3);

        // Misaligned write
        preload(1, 32'd1, 32'h0101_0101);
        access(1, 1'b0, 32'h6, 32'hCAFE_F00D, 4'hF, -1, 32'h0, 32'h0, rd, lat);
        check("mis_lat",     32'(lat), 32'd1);
        access(1, 1'b0, 32'h4, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
`ifdef NATIVE_MEM_MISALIGN_CHECK_EN
        check("mis_data",    rd,       32'h0101_0101);
        check("mis_err",     {31'd0, err[1]}, 32'd1);
`else
        check("mis_data",    rd,       32'hCAFE_F00D);
        check("mis_err",     {31'd0, err[1]}, 32'd0);
`endif

        // Reset mid-access with WAIT_CYCLES=3
        preload(2, 32'd2, 32'h1234_5678);
        access(2, 1'b0, 32'h8, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("w3_lat",      32'(lat), 32'd4);
        check("w3_rdata",    rd,       32'h1234_5678);
        @(negedge clk);
        valid[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'hDEAD_BEEF; wstrb[2] = 4'hF;
        @(posedge clk); #1;
        rst[2] = 1'b1; valid[2] = 1'b0; wstrb[2] = 4'h0;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= rdy[2]; end
        rst[2] = 1'b0;
        repeat (6) begin @(negedge clk); seen |= rdy[2]; end
        check("rst_mid_noready", {31'd0, seen}, 32'd0);
        check("rst_mid_rdata",   rdata[2],        32'd0);
        check("rst_mid_err",     {31'd0, err[2]}, 32'd0);
        check("rst_mid_fcnt",    fcnt[2],         32'd0);
        check("rst_mid_xcnt",    xcnt[2],         32'd0);
        access(2, 1'b0, 32'h8, 32'h0, 4'h0, -1, 32'h0, 32'h0, rd, lat);
        check("rst_mid_ram",     rd,              32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/native_mem_slave.md
# native_mem_slave

Synthesizable responder for the picorv32 native memory interface, sitting directly downstream of the core's `mem_*` port. It holds a word-addressed RAM, inserts a fixed number of wait states per access, and applies byte-strobed writes. It flags out-of-range accesses and counts instruction and total transfers. It replaces the behavioural memory loop in benches and gives a single response model shared by simulation and FPGA builds.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words. Must be a power of two, ≥ 16.
- `WAIT_CYCLES`, 1: wait states inserted between accept and response, range 0–15.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: request from the core.
- `mem_instr` in 1: request is an instruction fetch.
- `mem_addr` in 32: byte address; word index is `mem_addr[31:2]`.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 means read.
- `mem_ready` out 1: registered response strobe, one cycle wide.
- `mem_rdata` out 32: registered read data.
- `ld_we` in 1: backdoor preload write enable.
- `ld_addr` in 32: preload word index.
- `ld_data` in 32: preload data.
- `err` out 1: sticky error flag.
- `fetch_cnt` out 32: number of completed fetches.
- `xfer_cnt` out 32: number of completed transfers.

## Operation
- FSM states:
  - IDLE: if `mem_valid` is high, latch addr, wdata, wstrb and instr, and load the wait counter with `WAIT_CYCLES`. Go to WAIT, or to RESP if `WAIT_CYCLES` is 0.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
  - RESP: `mem_ready` is 1 for this cycle only. Return to IDLE.
- Reads: `mem_rdata` is loaded with RAM[word] on the edge entering RESP. It holds that value until the next read response. Writes do not update `mem_rdata`.
- Writes: each byte lane with `wstrb[i]` set is committed on the edge entering RESP.
- Out of range (word index ≥ `MEM_WORDS`):
  - No write occurs.
  - A read returns 0.
  - `err` is set; it is cleared only by `reset`.
  - The response is still given with normal timing.
- Inputs are sampled only in IDLE. Changes to `mem_valid` or `mem_addr` during WAIT or RESP are ignored, and the latched request completes.
- Preload: when `ld_we` is high, RAM[`ld_addr` mod `MEM_WORDS`] is written every cycle, independent of the FSM. If a preload and a CPU commit hit the same word on the same edge, CPU-strobed bytes win and the remaining bytes take `ld_data`.
- Counters: at RESP, `xfer_cnt` increments by 1, and `fetch_cnt` also increments if the latched instr is 1. Both wrap modulo 2^32.

## Timing
- Cycle 0 is the cycle in which IDLE samples `mem_valid` = 1. `mem_ready` = 1 in cycle 1 + `WAIT_CYCLES`.
- Back-to-back: IDLE can accept in the cycle immediately after RESP. The minimum request period is 2 + `WAIT_CYCLES` cycles.
- Reset values: `mem_ready` 0, `mem_rdata` 0, `err` 0, `fetch_cnt` 0, `xfer_cnt` 0, FSM in IDLE.
- Reset asserted mid-access: the access is dropped, no RAM commit occurs, and no `mem_ready` is issued. RAM contents are not reset.
- The preload write is visible to a CPU read that enters RESP on a later edge.

## Configuration
- `NATIVE_MEM_MISALIGN_CHECK_EN`
  - Defined: an access is misaligned if `mem_addr[1:0]` ≠ 0 and `mem_wstrb` ≠ 0, or if it is a fetch with `mem_addr[1:0]` ≠ 0. A misaligned access is treated like an out-of-range access: no write, rdata 0, `err` set, normal response timing.
  - Undefined: `mem_addr[1:0]` is ignored.

## Structure
- Shared package `native_mem_pkg` holds:
  - The FSM state enum (IDLE, WAIT, RESP).
  - The `nm_req_t` struct for the latched request: addr, wdata, wstrb, instr.
  - Width constants for the wait counter.
- One sub-module, `native_mem_ram`: a single-write-port RAM with byte enables, merged preload port and asynchronous read.
- FSM, counters and error logic live in the top module.

## Test plan
- `WAIT_CYCLES`=2: fetch at 0x0 with RAM[0]=0x00500093 preloaded → `mem_ready` in cycle 3, `mem_rdata`=0x00500093, `fetch_cnt`=1, `xfer_cnt`=1.
- RAM[4]=0x11223344; write to 0x10 with wstrb=0010 and wdata=0xAABBCCDD; then read 0x10 → 0x1122CC44.
- `MEM_WORDS`=1024: read at 0x1000 → `mem_rdata`=0, `err`=1, `mem_ready` at normal latency. A second, valid access leaves `err`=1.
- `WAIT_CYCLES`=0: three back-to-back reads → `mem_ready` pulses exactly 2 cycles apart, and `xfer_cnt`=3.
- `WAIT_CYCLES`=3: write to 0x8 with reset asserted in WAIT → no `mem_ready`, RAM[2] unchanged, all outputs back to reset values.
- With the macro defined: write to 0x6 with wstrb=1111 → no write, `err`=1. Without the macro: the same access writes RAM[1].
